// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin arbiter: FSM state encoding and default sizing.
package rr_arb_pkg;
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  localparam int DEF_IDX_W = 2;
endpackage

// File: rtl/rr_prio_enc.sv
// Rotating priority encoder: the lowest index at or after ptr (mod N) that requests wins.
module rr_prio_enc
  import rr_arb_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W,
  parameter int N     = 1 << IDX_W
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] win_idx,
  output logic             win_valid
);
  logic [2*N-1:0]   req_dbl;
  logic [N-1:0]     req_rot;
  logic [IDX_W-1:0] off;

  assign req_dbl = {req, req};
  // rot[i] corresponds to requester (ptr + i) mod N
  assign req_rot = req_dbl[ptr +: N];

  always_comb begin
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_rot[i]) off = IDX_W'(i);
    end
  end

  assign win_valid = |req;
  assign win_idx   = off + ptr;
endmodule

// File: rtl/rr_arbiter_anybit.sv
// Round-robin arbiter for N = 2^IDX_W requesters; holds a grant until done,
// owner drop, or MAX_HOLD cycles, then idles one cycle before the next grant.
module rr_arbiter_anybit
  import rr_arb_pkg::*;
#(
  parameter int IDX_W    = DEF_IDX_W,
  parameter int N        = 1 << IDX_W,
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [N-1:0]     req,
  input  logic             done,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);
  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic             timeout_q, timeout_d;

  logic [IDX_W-1:0] win_idx;
  logic             win_valid;
  logic             owner_req;
  logic             hold_max;

  rr_prio_enc #(.IDX_W(IDX_W), .N(N)) u_enc (
    .req      (req),
    .ptr      (ptr_q),
    .win_idx  (win_idx),
    .win_valid(win_valid)
  );

  assign owner_req = req[idx_q];
  assign hold_max  = (hold_q == HOLD_W'(MAX_HOLD));

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (enable && win_valid) begin
          idx_d   = win_idx;
          hold_d  = HOLD_W'(1);
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (done || !owner_req || hold_max) begin
          // timeout flags only a purely forced release
          timeout_d = hold_max && !done && owner_req;
          ptr_d     = idx_q + IDX_W'(1);
          idx_d     = '0;
          hold_d    = '0;
          state_d   = ST_IDLE;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt_valid = (state_q == ST_GRANT);
  assign gnt       = gnt_valid ? (N'(1) << idx_q) : '0;
  assign gnt_idx   = idx_q;
  assign timeout   = timeout_q;
endmodule

// File: tb/tb_rr_arbiter_anybit.sv
// Scoreboarded bench for rr_arbiter_anybit: directed scenarios then random traffic.
module tb_rr_arbiter_anybit;
  localparam int IDX_W    = 2;
  localparam int N        = 4;
  localparam int MAX_HOLD = 4;
  localparam int HOLD_W   = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b1;
  logic [N-1:0]     req = '1;
  logic             done = 1'b0;
  logic [N-1:0]     gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             timeout;

  rr_arbiter_anybit #(.IDX_W(IDX_W), .N(N), .MAX_HOLD(MAX_HOLD), .HOLD_W(HOLD_W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .req(req), .done(done),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]     gnt;
    logic [IDX_W-1:0] idx;
    logic             vld;
    logic             to;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: owner is -1 when idle, otherwise the requester holding the grant.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;
  bit m_to    = 0;

  always @(posedge clk) begin
    obs_t e;
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_hold = 0; m_to = 0;
    end else if (m_owner < 0) begin
      m_to = 0;
      if (enable && req != 0) begin
        for (int k = 0; k < N; k++) begin
          if (m_owner < 0 && req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
        end
        m_hold = 1;
      end
    end else begin
      m_to = 0;
      if (done || !req[m_owner] || m_hold == MAX_HOLD) begin
        m_to    = !done && req[m_owner] && (m_hold == MAX_HOLD);
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_hold  = 0;
      end else begin
        m_hold++;
      end
    end
    e.gnt = (m_owner < 0) ? '0 : N'(1 << m_owner);
    e.idx = (m_owner < 0) ? '0 : IDX_W'(m_owner);
    e.vld = (m_owner >= 0);
    e.to  = m_to;
    exp_q.push_back(e);
  end

  // Monitor: every cycle the DUT presents a settled output set; compare on the falling edge.
  always @(negedge clk) begin
    obs_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{gnt: gnt, idx: gnt_idx, vld: gnt_valid, to: timeout};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL scoreboard t=%0t: got gnt=%b idx=%0d vld=%b to=%b, want gnt=%b idx=%0d vld=%b to=%b",
                 $time, a.gnt, a.idx, a.vld, a.to, e.gnt, e.idx, e.vld, e.to);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // reset with all requesting
    cyc(2);
    check("reset_gnt", int'(gnt), 0);
    check("reset_timeout", int'(timeout), 0);
    rst = 1'b0;
    cyc(1);
    check("first_grant_idx0", int'(gnt), 4'b0001);
    req = '0; done = 1'b1; cyc(1); done = 1'b0;
    cyc(1);

    // single request, then wrap cases
    req = 4'b0100; cyc(1);
    check("single_gnt", int'(gnt), 4'b0100);
    check("single_idx", int'(gnt_idx), 2);
    done = 1'b1; cyc(1); done = 1'b0;
    check("done_release", int'(gnt_valid), 0);
    req = 4'b0011; cyc(1);
    check("wrap_ptr3_idx", int'(gnt_idx), 0);
    req = '0; cyc(1);
    check("drop_release_to", int'(timeout), 0);
    req = 4'b1001; cyc(1);
    check("wrap_ptr1_idx", int'(gnt_idx), 3);
    req = '0; cyc(1);

    // rotation with done on every grant
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      check("rotation_idx", int'(gnt_idx), i % N);
      done = 1'b1; cyc(1); done = 1'b0;
      check("rotation_idle", int'(gnt_valid), 0);
    end
    req = '0; cyc(1);

    // timeout on a sole requester
    req = 4'b0001; cyc(1);
    for (int i = 0; i < MAX_HOLD; i++) begin
      check("hold_valid", int'(gnt_valid), 1);
      cyc(1);
    end
    check("timeout_release", int'(gnt_valid), 0);
    check("timeout_pulse", int'(timeout), 1);
    cyc(1);
    check("regrant_idx0", int'(gnt), 4'b0001);
    check("timeout_one_cycle", int'(timeout), 0);

    // enable low keeps grant; owner drop releases
    enable = 1'b0; cyc(2);
    check("enable0_keeps", int'(gnt_valid), 1);
    req = '0; cyc(1);
    check("drop_release", int'(gnt_valid), 0);
    check("drop_no_timeout", int'(timeout), 0);
    enable = 1'b1;

    // done coinciding with hold limit
    req = 4'b0001; cyc(1); cyc(MAX_HOLD - 1);
    done = 1'b1; cyc(1); done = 1'b0;
    check("done_at_max_to", int'(timeout), 0);
    check("done_at_max_vld", int'(gnt_valid), 0);

    // reset mid-grant drops grant and clears ptr
    cyc(1);
    check("pre_rst_grant", int'(gnt_valid), 1);
    rst = 1'b1; cyc(1);
    check("mid_rst_gnt", int'(gnt), 0);
    rst = 1'b0; req = 4'b1111; cyc(1);
    check("post_rst_idx", int'(gnt_idx), 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) req = N'($urandom);
      done   = ($urandom_range(4) == 0);
      enable = ($urandom_range(4) != 0);
      rst    = ($urandom_range(299) == 0);
      cyc(1);
    end
    rst = 1'b0; done = 1'b0;
    cyc(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
